zbus_source_q: RTL

ZBUS_SOURCE_Q -- requirements
Module: zbus_source_q

---
 rtl/zbus_source_q.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/zbus_source_q.sv
// Queued zbus source: buffers loaded words in a small FIFO and presents them
// on a valid/ack zbus, with back-to-back, fixed-gap or LFSR-throttled pacing.
module zbus_source_q #(
  parameter int          BW    = 8,
  parameter int          DEPTH = 4,
  parameter int          MODE  = 0,
  parameter int          GAP   = 1,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          CW    = 16,
  parameter logic        XZ    = 1'bx
) (
  input  logic          z_clk,
  input  logic          z_rst,
  input  logic          l_vld,
  input  logic [BW-1:0] l_bus,
  output logic          l_rdy,
  output logic          z_vld,
  output logic [BW-1:0] z_bus,
  input  logic          z_ack,
  output logic [CW-1:0] cnt,
  output logic          emp
);

  localparam int            AW     = $clog2(DEPTH);
  localparam int            OW     = AW + 1;
  localparam logic [BW-1:0] FILL   = {BW{XZ}};
  localparam bit            B2B    = (MODE == 0) || (MODE == 1 && GAP == 0);
  localparam bit            GAPPED = (MODE == 1) && (GAP > 0);

  typedef enum logic [1:0] {S_IDLE, S_VALID, S_GAP} state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  logic [BW-1:0] mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [7:0]    gcnt_q, gcnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_vld_q, z_vld_d;
  logic [BW-1:0] z_bus_q, z_bus_d;
  logic          l_rdy_q, l_rdy_d;
  logic          emp_q, emp_d;
  logic          load, pop, xfer, permit;

  always_comb begin
    load    = l_vld & l_rdy_q;
    xfer    = z_vld_q & z_ack;
    permit  = (MODE != 2) || lfsr_q[0];
    pop     = 1'b0;
    state_d = state_q;
    gcnt_d  = gcnt_q;
    z_vld_d = z_vld_q;
    z_bus_d = z_bus_q;

    unique case (state_q)
      S_IDLE: begin
        if (occ_q != '0 && permit) begin
          pop     = 1'b1;
          state_d = S_VALID;
          z_vld_d = 1'b1;
          z_bus_d = mem_q[rd_ptr_q];
        end
      end
      S_VALID: begin
        if (xfer) begin
          // Sustained streaming: pop the next word on the same edge as the ack.
          if (B2B && occ_q != '0) begin
            pop     = 1'b1;
            z_bus_d = mem_q[rd_ptr_q];
          end else begin
            z_vld_d = 1'b0;
            z_bus_d = FILL;
            if (GAPPED) begin
              state_d = S_GAP;
              gcnt_d  = 8'(GAP - 1);
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        if (gcnt_q == '0) state_d = S_IDLE;
        else              gcnt_d  = gcnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = load ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({load, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    cnt_d   = xfer ? cnt_q + CW'(1) : cnt_q;
    l_rdy_d = (occ_d != OW'(DEPTH));
    emp_d   = (occ_d == '0) && !z_vld_d;
    lfsr_d  = lfsr_next(lfsr_q);
  end

  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      gcnt_q   <= '0;
      lfsr_q   <= SEED;
      cnt_q    <= '0;
      z_vld_q  <= 1'b0;
      z_bus_q  <= FILL;
      l_rdy_q  <= 1'b1;
      emp_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      gcnt_q   <= gcnt_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      z_vld_q  <= z_vld_d;
      z_bus_q  <= z_bus_d;
      l_rdy_q  <= l_rdy_d;
      emp_q    <= emp_d;
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge z_clk) begin
    if (load) mem_q[wr_ptr_q] <= l_bus;
  end

  assign l_rdy = l_rdy_q;
  assign z_vld = z_vld_q;
  assign z_bus = z_bus_q;
  assign cnt   = cnt_q;
  assign emp   = emp_q;

endmodule
